// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM state
// encoding, IR field positions and the opcode classification helper.
package cpu_ctrl_pkg;

  // ALU / control opcodes carried in ir[31:27]
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // IR field bit positions
  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_DONE, ST_HALTED
  } state_t;

  // Execution shape shared by groups of opcodes
  typedef enum logic [2:0] {
    CL_ALU2, CL_MULDIV, CL_UNARY, CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CL_ALU2;
      OP_MUL, OP_DIV:                 return CL_MULDIV;
      OP_NEG, OP_NOT:                 return CL_UNARY;
      OP_NOP:                         return CL_NOP;
      OP_HALT:                        return CL_HALT;
      default:                        return CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_dec.sv
// Register index decoder: 4-bit index plus enable to a one-hot select.
module reg_select_dec #(
  parameter int NREGS = 16
) (
  input  logic [3:0]       idx,
  input  logic             en,
  output logic [NREGS-1:0] sel
);

  // At most one bit set; none when disabled
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      sel[i] = en && (idx == 4'(i));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for fetch and execution of register-register
// ALU instructions. Outputs are decoded purely from the state register and
// the IR fields captured when leaving T2, so a changing ir after fetch
// cannot disturb an instruction in flight.
//
// Memory handshake: during T1 the sequencer holds read/MDRin and waits;
// mem_ready=1 in a T1 cycle means Mdatain is valid that cycle, and the
// sequencer moves to T2 on the following edge. mem_ready is ignored in
// every other state.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             incPC,
  output logic             Zin,
  output logic             Yin,
  output logic             PCin,
  output logic             read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             ZLowOut,
  output logic             ZHighOut,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] reg_in,
  output logic [NREGS-1:0] reg_out,
  output logic [OPW-1:0]   opcode,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state_dbg
);

  state_t    state_q, state_d;
  logic [4:0] op_q;
  logic [3:0] ra_q, rb_q, rc_q;
  logic       t1_seen_q;
  op_class_t  cls;
  logic [3:0] in_idx, out_idx;
  logic       in_en, out_en, opc_en;

  assign cls       = op_class(op_q);
  assign state_dbg = state_q;
  assign opcode    = opc_en ? OPW'(op_q) : '0;

  // State register; T1 first-cycle flag; IR field capture on the T2->T3 edge
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      t1_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_seen_q <= (state_q == ST_T1);
      if (state_q == ST_T2) begin
        op_q <= ir[IR_OP_HI:IR_OP_LO];
        ra_q <= ir[IR_RA_HI:IR_RA_LO];
        rb_q <= ir[IR_RB_HI:IR_RB_LO];
        rc_q <= ir[IR_RC_HI:IR_RC_LO];
      end
    end
  end

  // Next state and Moore strobe decode
  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    MARin    = 1'b0;
    incPC    = 1'b0;
    Zin      = 1'b0;
    Yin      = 1'b0;
    PCin     = 1'b0;
    read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    opc_en   = 1'b0;
    in_en    = 1'b0;
    in_idx   = '0;
    out_en   = 1'b0;
    out_idx  = '0;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        // PC reload happens once even if memory stalls
        ZLowOut = 1'b1; read = 1'b1; MDRin = 1'b1;
        PCin    = !t1_seen_q;
        if (mem_ready) state_d = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        case (cls)
          CL_ALU2:   begin out_en = 1'b1; out_idx = rb_q; Yin = 1'b1; state_d = ST_T4; end
          CL_MULDIV: begin out_en = 1'b1; out_idx = ra_q; Yin = 1'b1; state_d = ST_T4; end
          CL_UNARY: begin
            out_en = 1'b1; out_idx = rb_q; opc_en = 1'b1; Zin = 1'b1;
            state_d = ST_T4;
          end
          CL_NOP:    state_d = ST_DONE;
          CL_HALT:   state_d = ST_HALTED;
          default:   begin illegal = 1'b1; state_d = ST_DONE; end
        endcase
      end
      ST_T4: begin
        case (cls)
          CL_ALU2: begin
            out_en = 1'b1; out_idx = rc_q; opc_en = 1'b1; Zin = 1'b1;
            state_d = ST_T5;
          end
          CL_MULDIV: begin
            out_en = 1'b1; out_idx = rb_q; opc_en = 1'b1; Zin = 1'b1;
            state_d = ST_T5;
          end
          CL_UNARY: begin
            ZLowOut = 1'b1; in_en = 1'b1; in_idx = ra_q;
            state_d = ST_DONE;
          end
          default: state_d = ST_DONE;
        endcase
      end
      ST_T5: begin
        case (cls)
          CL_ALU2:   begin ZLowOut = 1'b1; in_en = 1'b1; in_idx = ra_q; state_d = ST_DONE; end
          CL_MULDIV: begin ZLowOut = 1'b1; LOin = 1'b1; state_d = ST_T6; end
          default:   state_d = ST_DONE;
        endcase
      end
      ST_T6: begin
        ZHighOut = 1'b1; HIin = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE:   state_d = run ? ST_T0 : ST_IDLE;
      ST_HALTED: halted = 1'b1;
      default:   state_d = ST_IDLE;
    endcase
  end

  reg_select_dec #(.NREGS(NREGS)) u_in_dec (
    .idx (in_idx),
    .en  (in_en),
    .sel (reg_in)
  );

  reg_select_dec #(.NREGS(NREGS)) u_out_dec (
    .idx (out_idx),
    .en  (out_en),
    .sel (reg_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: per-cycle expected strobe snapshots are
// queued alongside the inputs that produce them, then applied and compared.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        run = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;
  logic        PCout, MARin, incPC, Zin, Yin, PCin, read, MDRin, MDRout, IRin;
  logic        ZLowOut, ZHighOut, HIin, LOin, halted, illegal;
  logic [15:0] reg_in, reg_out;
  logic [4:0]  opcode;
  logic [3:0]  state_dbg;

  typedef struct packed {
    logic pcout, marin, incpc, zin, yin, pcin, read, mdrin, mdrout, irin;
    logic zlow, zhigh, hiin, loin, halted, illegal;
    logic [4:0]  opc;
    logic [15:0] rin;
    logic [15:0] rout;
  } outs_t;
  localparam int W = $bits(outs_t);

  typedef struct {
    logic [4:0] op;
    int         stalls;
  } vec_t;

  logic [W-1:0]  exp_q[$];
  logic [33:0]   in_q[$];
  int            errors = 0;
  int            checks = 0;
  int            step = 0;

  control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .incPC(incPC), .Zin(Zin), .Yin(Yin),
    .PCin(PCin), .read(read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
    .reg_in(reg_in), .reg_out(reg_out), .opcode(opcode),
    .halted(halted), .illegal(illegal), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clock = ~clock;

  function automatic outs_t sample();
    outs_t s;
    s = '{pcout: PCout, marin: MARin, incpc: incPC, zin: Zin, yin: Yin,
          pcin: PCin, read: read, mdrin: MDRin, mdrout: MDRout, irin: IRin,
          zlow: ZLowOut, zhigh: ZHighOut, hiin: HIin, loin: LOin,
          halted: halted, illegal: illegal, opc: opcode, rin: reg_in, rout: reg_out};
    return s;
  endfunction

  // 1 two-operand, 2 mul/div, 3 unary, 4 nop, 5 halt, 0 undefined
  function automatic int classify(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b01001, 5'b01010,
      5'b00101, 5'b00110, 5'b00111, 5'b01000: return 1;
      5'b01111, 5'b10000: return 2;
      5'b10001, 5'b10010: return 3;
      5'b11010: return 4;
      5'b11011: return 5;
      default:  return 0;
    endcase
  endfunction

  task automatic push(input logic r, input logic mr, input logic [31:0] irv, input outs_t e);
    in_q.push_back({r, mr, irv});
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] onehot(input logic [3:0] i);
    logic [15:0] v;
    v = 16'd1;
    return v << i;
  endfunction

  // Expected cycle-by-cycle strobes for one instruction, starting at T0
  task automatic gen_instr(input logic [31:0] irv, input int stalls, input logic run_late);
    outs_t e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [31:0] junk;
    int cls;
    op = irv[31:27]; ra = irv[26:23]; rb = irv[22:19]; rc = irv[18:15];
    junk = ~irv;
    cls = classify(op);
    e = '0; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
    push(1'b1, 1'b0, irv, e);
    e = '0; e.zlow = 1; e.read = 1; e.mdrin = 1; e.pcin = 1;
    push(1'b1, 1'b0, irv, e);
    e.pcin = 0;
    for (int s = 0; s < stalls; s++) push(1'b1, 1'b0, irv, e);
    e = '0; e.mdrout = 1; e.irin = 1;
    push(1'b1, 1'b1, irv, e);
    // T3: this edge captures ir, later edges see a scrambled ir
    e = '0;
    case (cls)
      1: begin e.rout = onehot(rb); e.yin = 1; end
      2: begin e.rout = onehot(ra); e.yin = 1; end
      3: begin e.rout = onehot(rb); e.opc = op; e.zin = 1; end
      0: e.illegal = 1;
      default: ;
    endcase
    push(run_late, 1'b0, irv, e);
    if (cls == 5) begin
      e = '0; e.halted = 1;
      push(run_late, 1'b0, junk, e);
      return;
    end
    if (cls == 1 || cls == 2) begin
      e = '0; e.rout = (cls == 1) ? onehot(rc) : onehot(rb); e.opc = op; e.zin = 1;
      push(run_late, 1'b0, junk, e);
      e = '0; e.zlow = 1;
      if (cls == 1) e.rin = onehot(ra); else e.loin = 1;
      push(run_late, 1'b0, junk, e);
      if (cls == 2) begin
        e = '0; e.zhigh = 1; e.hiin = 1;
        push(run_late, 1'b0, junk, e);
      end
    end else if (cls == 3) begin
      e = '0; e.zlow = 1; e.rin = onehot(ra);
      push(run_late, 1'b0, junk, e);
    end
    push(run_late, 1'b0, junk, '0);  // DONE
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, $urandom(), '0);
  endtask

  // Apply queued inputs one edge at a time and compare the next state's strobes
  task automatic process(input int n);
    logic [33:0] iv;
    logic [W-1:0] ev, av;
    for (int i = 0; i < n && in_q.size() > 0; i++) begin
      iv = in_q.pop_front();
      run = iv[33]; mem_ready = iv[32]; ir = iv[31:0];
      @(posedge clock);
      @(negedge clock);
      ev = exp_q.pop_front();
      av = sample();
      checks++;
      step++;
      if (av !== ev) begin
        errors++;
        $display("FAIL step%0d strobes got=%h exp=%h", step, av, ev);
      end
    end
  endtask

  task automatic check_zero(input string name);
    logic [W-1:0] av;
    av = sample();
    checks++;
    if (av !== '0) begin
      errors++;
      $display("FAIL %s got=%h exp=0", name, av);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    logic [14:0] low;
    low = 15'($urandom());
    return {op, ra, rb, rc, low};
  endfunction

  vec_t tbl[16];

  initial begin
    tbl = '{'{5'b00011, 0}, '{5'b00100, 1}, '{5'b01001, 0}, '{5'b01010, 2},
            '{5'b00101, 0}, '{5'b00110, 0}, '{5'b00111, 1}, '{5'b01000, 0},
            '{5'b01111, 2}, '{5'b10000, 0}, '{5'b10001, 0}, '{5'b10010, 1},
            '{5'b11010, 0}, '{5'b00000, 0}, '{5'b10011, 1}, '{5'b11100, 0}};

    // Reset state
    repeat (2) @(negedge clock);
    check_zero("reset");
    clear = 1'b1;
    push_idle(2);
    process(100);

    // add R7 = R4 + R3, no memory stall
    gen_instr(mk_ir(5'b00011, 4'd7, 4'd4, 4'd3), 0, 1'b1);
    push_idle(1);
    process(100);

    // mul ra=2, rb=5
    gen_instr(mk_ir(5'b01111, 4'd2, 4'd5, 4'd0), 0, 1'b1);
    push_idle(1);
    process(100);

    // three stall cycles in T1
    gen_instr(mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 3, 1'b1);
    push_idle(1);
    process(100);

    // undefined opcode, then back-to-back fetch of the next instruction
    gen_instr(mk_ir(5'b11111, 4'd9, 4'd9, 4'd9), 0, 1'b1);
    gen_instr(mk_ir(5'b00100, 4'd15, 4'd0, 4'd14), 0, 1'b1);
    push_idle(1);
    process(100);

    // Table sweep with random register fields and stalls
    for (int i = 0; i < 16; i++) begin
      gen_instr(mk_ir(tbl[i].op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15))),
                tbl[i].stalls + $urandom_range(0, 1), 1'b1);
      push_idle(1);
      process(100);
    end

    // run dropped from T2 onward: instruction still completes, then IDLE
    gen_instr(mk_ir(5'b00011, 4'd6, 4'd8, 4'd10), 0, 1'b0);
    push_idle(2);
    process(100);

    // async clear in T4 of an add
    gen_instr(mk_ir(5'b00011, 4'd7, 4'd4, 4'd3), 0, 1'b1);
    process(5);
    in_q.delete();
    exp_q.delete();
    #1 clear = 1'b0;
    #1 check_zero("clear_in_t4");
    @(negedge clock);
    clear = 1'b1;
    gen_instr(mk_ir(5'b00011, 4'd7, 4'd4, 4'd3), 0, 1'b1);
    push_idle(1);
    process(100);

    // halt: stays halted with run=1 for 20 cycles
    gen_instr(mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      outs_t e;
      e = '0; e.halted = 1;
      push(1'b1, 1'b1, $urandom(), e);
    end
    process(100);
    #1 clear = 1'b0;
    #1 check_zero("clear_from_halt");
    @(negedge clock);
    clear = 1'b1;
    push_idle(2);
    process(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Moore FSM that generates the datapath control strobes for fetch and execution of Phase-1 register-register ALU instructions.
- Replaces hand-sequenced control: it consumes the IR and memory handshake, and emits PCout/MARin/incPC/Zin/Yin/register select/opcode strobes.
- Sits between memory/IR and the datapath; its outputs connect one-to-one to datapath control inputs.

Parameters:
- NREGS, 16, number of general registers; width of reg_in/reg_out
- OPW, 5, ALU opcode width

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = fetch next instruction when idle
- ir  in  32  instruction register; opcode[31:27], ra[26:23], rb[22:19], rc[18:15]
- mem_ready  in  1  memory read data valid on Mdatain this cycle
- PCout, MARin, incPC, Zin, Yin, PCin, read, MDRin, MDRout, IRin  out  1 each  datapath strobes
- ZLowOut, ZHighOut, HIin, LOin  out  1 each  Z/HI/LO strobes
- reg_in  out  NREGS  one-hot register write enable (R0in..R15in)
- reg_out  out  NREGS  one-hot register drive enable (R0out..R15out)
- opcode  out  OPW  ALU operation; 0 outside execute states
- halted  out  1  sequencer stopped on HALT
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset (clear=0, async): state IDLE; every output 0. Reset mid-instruction aborts it with no further strobes.
- Moore outputs: decoded from state and latched ir fields. At most one bit of reg_out set; at most one bus driver per state.
- IDLE: run=1 -> T0 on next edge; otherwise hold.
- T0: PCout, MARin, incPC, Zin -> T1.
- T1: ZLowOut, PCin, read, MDRin. Hold T1 while mem_ready=0; PCin is asserted only in the first T1 cycle. mem_ready=1 -> T2.
- T2: MDRout, IRin -> T3. On the T2->T3 edge the sequencer captures ir opcode/ra/rb/rc into internal registers.
- Decode in T3 from the captured opcode:
  - Two-operand ops: add 00011, sub 00100, and 01001, or 01010, shr 00101, shl 00110, ror 00111, rol 01000.
    - T3: reg_out[rb], Yin.
    - T4: reg_out[rc], opcode=op, Zin.
    - T5: ZLowOut, reg_in[ra] -> DONE.
  - mul 01111 / div 10000:
    - T3: reg_out[ra], Yin.
    - T4: reg_out[rb], opcode, Zin.
    - T5: ZLowOut, LOin.
    - T6: ZHighOut, HIin -> DONE.
  - neg 10001 / not 10010:
    - T3: reg_out[rb], opcode, Zin.
    - T4: ZLowOut, reg_in[ra] -> DONE.
  - nop 11010: T3 has no strobes -> DONE.
  - halt 11011: -> HALTED. halted=1 and held until reset; run is ignored.
  - Any other opcode: illegal=1 for the T3 cycle; no register write; -> DONE.
- DONE: no strobes. run=1 -> T0; run=0 -> IDLE.
- Latency, with mem_ready asserted during T1: add is 6 cycles T0..T5; mul is 7; not is 5. Each mem_ready=0 cycle adds one.
- Dropping run mid-instruction has no effect until DONE.
- Register indices are 4 bits; with NREGS=16 every index is valid.
- Write to R0: reg_in[0] is asserted normally; R0 semantics belong to the datapath.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (ADD=5'b00011 ... HALT=5'b11011);
  - state encoding (IDLE, T0..T6, DONE, HALTED);
  - IR field bit positions.
- Sub-module reg_select_dec: 4-bit index + enable -> NREGS one-hot. Instantiated twice, for reg_in and reg_out.

Test Plan:
- Reset, then run=1, ir={00011,ra=7,rb=4,rc=3}, mem_ready=1: T0..T5 over 6 cycles. reg_out=0x0010 with Yin at T3; reg_out=0x0008 with opcode=00011 and Zin at T4; reg_in=0x0080 with ZLowOut at T5. R4=30, R3=25 in the datapath gives R7=55.
- mul ra=2, rb=5: LOin with ZLowOut at T5, HIin with ZHighOut at T6. R2=0x10000, R5=0x10000 gives HI=1, LO=0.
- mem_ready held 0 for 3 cycles in T1: read/MDRin stay high 4 cycles, PCin high only in the first; IRin appears on the cycle after mem_ready=1.
- Opcode 11111: illegal pulses exactly 1 cycle, reg_in stays 0, next instruction fetch starts at T0. halt 11011: halted=1 and no strobes for 20 cycles with run=1.
- clear driven low during T4 of an add: all outputs 0 immediately, without waiting for a clock edge. After release with run=1, fetch restarts at T0.
- run dropped during T2: instruction completes through T5, then IDLE with all strobes 0.
